sparc_exec_unit: RTL and testbench
==================================

Name: sparc_exec_unit

Overview:
- Execution slice of the SPARC-subset datapath: a windowed register file, a 32-bit ALU with integer condition codes, and the trap-base adder.
- Sits between the control unit, the IR/operand muxes, and the PSR, nPC and TBR registers.
- Register-file and flag writes are clocked; the ALU and trap-base paths are combinational.

Parameters:
- NWIN, 4, number of register windows; CWP input width is clog2(NWIN).
- TB_STEP, 4, increment the trap-base adder applies when tb_add is asserted.

Ports:
- Clk in 1: clock; all state updates on the rising edge.
- Clr in 1: asynchronous, active-high reset.
- cwp in 2: current window pointer.
- ra, rb, rc in 5 each: A-read, B-read and write register numbers.
- rin in 32: write data.
- rfe in 1: register write enable, active-low (codebase enable convention).
- a_out, b_out out 32: register read data.
- alu_a, alu_b in 32: ALU operands.
- alu_op in 6: SPARC op3.
- carry_in in 1: carry for ADDX/SUBX.
- alue in 1: flag-update enable, active-high.
- alu_out out 32: ALU result.
- n, z, v, c out 1: registered icc flags.
- tbr_in in 32: TBR value.
- tb_add in 1: selects incremented trap address.
- tb_out out 32: trap-base adder result.

Behaviour:
- Reset: Clr=1 asynchronously clears all 72 physical registers and n/z/v/c to 0. Outputs a_out, b_out, alu_out and tb_out stay combinational; with zero inputs they read 0.
- Register file has 8 globals plus NWIN×16 windowed registers.
  - r0 always reads 0; writes to r0 are discarded.
  - r1–r7 map to globals.
  - r8–r31 map to physical 8 + ((cwp×16 + (r−8)) mod (NWIN×16)). The wrap gives ins(w) == outs(w+1 mod NWIN).
- Reads are combinational and asynchronous.
- Write: on the rising Clk edge, if rfe==0 and rc!=0, register rc in window cwp ← rin.
- Simultaneous read and write of the same register returns the old value unless RF_BYPASS_EN is defined.
- ALU is combinational and uses alu_op[3:0] with alu_op[5:4]:
  - 0000 ADD; 0001 AND; 0010 OR; 0011 XOR; 0100 SUB; 0101 ANDN (a & ~b); 0110 ORN; 0111 XNOR; 1000 ADDX (a + b + carry_in); 1100 SUBX (a − b − carry_in).
  - alu_op[5:4]=01 selects the cc variant of the same op.
  - 100101 SLL, 100110 SRL, 100111 SRA: shift amount alu_b[4:0].
  - 111000 JMPL, 111100 SAVE, 111101 RESTORE, and all other codes compute a + b (address add).
- Flags are computed combinationally:
  - N = result[31].
  - Z = (result == 0).
  - V = signed overflow for add/sub; 0 for logic and shift ops.
  - C = carry-out for add, borrow for sub; 0 for logic and shift ops.
- Flags register on the rising edge only when alue==1 and alu_op[5:4]==01. Otherwise they hold.
- Trap-base adder: tb_out = tb_add ? tbr_in + TB_STEP : tbr_in. The sum is modulo 2^32 and wraps silently.
- Clr asserted mid-write: reset wins; no write occurs.

Optional Feature:
- RF_BYPASS_EN defined: a same-cycle read of the register being written (rfe==0, matching physical index, rc!=0) returns rin combinationally.
- Undefined: reads return the stored value. Default is undefined.

Decomposition:
- Package sparc_exec_pkg holds:
  - op3 localparams (OP_ADD, OP_AND, …, OP_SLL, OP_SRL, OP_SRA, OP_JMPL, OP_SAVE, OP_RESTORE, CC_BIT = 4);
  - NREGS_PHYS;
  - the window-mapping function.
- One natural sub-module: sparc_win_regfile (storage, mapping, bypass). ALU and trap adder stay inline.

Test Plan:
- Reset, then read r0 and r5 with cwp=0 → a_out = b_out = 0. Write r0 ← FFFFFFFF → r0 still reads 0.
- Window overlap: cwp=1, write r8 ← A5A5A5A5 with rfe=0 → cwp=0 reads r24 = A5A5A5A5. cwp=3 writes r24 ← 12345678 → cwp=0 reads r8 = 12345678 (wrap).
- ADDcc (010000) with a=7FFFFFFF, b=1, alue=1, then clock → alu_out = 80000000, n=1, z=0, v=1, c=0.
- SUBcc (010100) with a=b=5, then clock → z=1, c=0. Repeat with alue=0 and a=0, b=1 → flags unchanged.
- SRA 100111 with a=80000000, b=4 → F8000000. ADDX with a=1, b=1, carry_in=1 → 3.
- tbr_in=00000810: tb_add=0 → 00000810; tb_add=1 → 00000814. tbr_in=FFFFFFFC, tb_add=1 → 00000000.

Source files
------------

// File: rtl/sparc_exec_pkg.sv
// sparc_exec_pkg: shared constants for the SPARC-subset execution slice.
//   - op3 codes decoded by the ALU (CC_BIT selects the condition-code variant)
//   - register-file geometry (globals plus windowed registers)
//   - win_map(): architectural register number plus window pointer to physical index
package sparc_exec_pkg;

  localparam logic [5:0] OP_ADD     = 6'b000000;
  localparam logic [5:0] OP_AND     = 6'b000001;
  localparam logic [5:0] OP_OR      = 6'b000010;
  localparam logic [5:0] OP_XOR     = 6'b000011;
  localparam logic [5:0] OP_SUB     = 6'b000100;
  localparam logic [5:0] OP_ANDN    = 6'b000101;
  localparam logic [5:0] OP_ORN     = 6'b000110;
  localparam logic [5:0] OP_XNOR    = 6'b000111;
  localparam logic [5:0] OP_ADDX    = 6'b001000;
  localparam logic [5:0] OP_SUBX    = 6'b001100;
  localparam logic [5:0] OP_SLL     = 6'b100101;
  localparam logic [5:0] OP_SRL     = 6'b100110;
  localparam logic [5:0] OP_SRA     = 6'b100111;
  localparam logic [5:0] OP_JMPL    = 6'b111000;
  localparam logic [5:0] OP_SAVE    = 6'b111100;
  localparam logic [5:0] OP_RESTORE = 6'b111101;
  localparam int         CC_BIT     = 4;

  localparam int NGLOBALS    = 8;
  localparam int WIN_REGS    = 16;
  localparam int NWIN_DEF    = 4;
  localparam int NREGS_PHYS  = NGLOBALS + NWIN_DEF * WIN_REGS;

  // r0..r7 are globals; r8..r31 slide by 16 per window and wrap, so the
  // ins of window w alias the outs of window w+1.
  function automatic int unsigned win_map(input int unsigned cwp,
                                          input int unsigned r,
                                          input int unsigned nwin);
    int unsigned idx;
    if (r < NGLOBALS) idx = r;
    else idx = NGLOBALS + ((cwp * WIN_REGS + (r - NGLOBALS)) % (nwin * WIN_REGS));
    return idx;
  endfunction

endpackage

// File: rtl/sparc_win_regfile.sv
// sparc_win_regfile: windowed register file, 2 async read ports, 1 write port.
//   Clk, Clr      : clock, async active-high clear of every physical register
//   cwp           : current window pointer
//   ra, rb / a_out, b_out : read addresses / combinational read data (r0 reads 0)
//   rc, rin, rfe  : write address, data, active-low write enable (r0 writes dropped)
// RF_BYPASS_EN: when defined, a read of the register being written this cycle
// returns rin instead of the stored value.
module sparc_win_regfile
  import sparc_exec_pkg::*;
#(
  parameter int NWIN = 4,
  parameter int CWPW = 2
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic [CWPW-1:0] cwp,
  input  logic [4:0]      ra,
  input  logic [4:0]      rb,
  input  logic [4:0]      rc,
  input  logic [31:0]     rin,
  input  logic            rfe,
  output logic [31:0]     a_out,
  output logic [31:0]     b_out
);

  localparam int NPHYS = NGLOBALS + NWIN * WIN_REGS;
  localparam int PW    = $clog2(NPHYS);

  logic [NPHYS-1:0][31:0] regs;
  logic [PW-1:0]          ia, ib, iw;
  logic                   we;

  assign ia = PW'(win_map(32'(cwp), 32'(ra), NWIN));
  assign ib = PW'(win_map(32'(cwp), 32'(rb), NWIN));
  assign iw = PW'(win_map(32'(cwp), 32'(rc), NWIN));
  assign we = !rfe && (rc != 5'd0);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)     regs     <= '0;
    else if (we) regs[iw] <= rin;
  end

`ifdef RF_BYPASS_EN
  // rc != 0 keeps iw off physical 0, so r0 reads can never pick up rin.
  assign a_out = (ra == 5'd0) ? '0 : (we && iw == ia) ? rin : regs[ia];
  assign b_out = (rb == 5'd0) ? '0 : (we && iw == ib) ? rin : regs[ib];
`else
  assign a_out = (ra == 5'd0) ? '0 : regs[ia];
  assign b_out = (rb == 5'd0) ? '0 : regs[ib];
`endif

endmodule

// File: rtl/sparc_exec_unit.sv
// sparc_exec_unit: execution slice -- windowed register file, 32-bit ALU with
// registered icc flags, and the trap-base adder.
//   Clk, Clr                 : clock, async active-high reset
//   cwp, ra, rb, rc, rin, rfe : register file control (rfe active-low)
//   a_out, b_out             : register read data
//   alu_a, alu_b, alu_op, carry_in, alue : ALU operands, op3, carry, flag enable
//   alu_out, n, z, v, c      : ALU result (combinational), icc flags (registered)
//   tbr_in, tb_add, tb_out   : trap-base adder
// RF_BYPASS_EN: enables write-to-read forwarding inside the register file.
module sparc_exec_unit
  import sparc_exec_pkg::*;
#(
  parameter  int NWIN    = NWIN_DEF,
  parameter  int TB_STEP = 4,
  localparam int CWPW    = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic [CWPW-1:0] cwp,
  input  logic [4:0]      ra,
  input  logic [4:0]      rb,
  input  logic [4:0]      rc,
  input  logic [31:0]     rin,
  input  logic            rfe,
  output logic [31:0]     a_out,
  output logic [31:0]     b_out,
  input  logic [31:0]     alu_a,
  input  logic [31:0]     alu_b,
  input  logic [5:0]      alu_op,
  input  logic            carry_in,
  input  logic            alue,
  output logic [31:0]     alu_out,
  output logic            n,
  output logic            z,
  output logic            v,
  output logic            c,
  input  logic [31:0]     tbr_in,
  input  logic            tb_add,
  output logic [31:0]     tb_out
);

  sparc_win_regfile #(.NWIN(NWIN), .CWPW(CWPW)) u_rf (
    .Clk(Clk), .Clr(Clr), .cwp(cwp), .ra(ra), .rb(rb), .rc(rc),
    .rin(rin), .rfe(rfe), .a_out(a_out), .b_out(b_out)
  );

  // ---- ALU ----
  logic [5:0]  op_base;   // op3 with the cc bit stripped
  logic        cin_eff;
  logic [32:0] sum33, dif33;
  logic        add_v, sub_v;
  logic        vf, cf;

  assign op_base = {2'b00, alu_op[3:0]};
  // carry only feeds ADDX/SUBX; other low-bank codes are plain address adds.
  assign cin_eff = carry_in && !alu_op[5] && (op_base == OP_ADDX || op_base == OP_SUBX);
  assign sum33   = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, cin_eff};
  assign dif33   = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, cin_eff};
  assign add_v   = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
  assign sub_v   = (alu_a[31] != alu_b[31]) && (dif33[31] != alu_a[31]);

  always_comb begin
    alu_out = sum33[31:0];
    vf      = add_v;
    cf      = sum33[32];
    if (!alu_op[5]) begin
      unique case (op_base)
        OP_SUB, OP_SUBX: begin alu_out = dif33[31:0]; vf = sub_v; cf = dif33[32]; end
        OP_AND:  begin alu_out = alu_a & alu_b;    vf = 1'b0; cf = 1'b0; end
        OP_OR:   begin alu_out = alu_a | alu_b;    vf = 1'b0; cf = 1'b0; end
        OP_XOR:  begin alu_out = alu_a ^ alu_b;    vf = 1'b0; cf = 1'b0; end
        OP_ANDN: begin alu_out = alu_a & ~alu_b;   vf = 1'b0; cf = 1'b0; end
        OP_ORN:  begin alu_out = alu_a | ~alu_b;   vf = 1'b0; cf = 1'b0; end
        OP_XNOR: begin alu_out = ~(alu_a ^ alu_b); vf = 1'b0; cf = 1'b0; end
        default: ;
      endcase
    end else begin
      unique case (alu_op)
        OP_SLL: begin alu_out = alu_a << alu_b[4:0]; vf = 1'b0; cf = 1'b0; end
        OP_SRL: begin alu_out = alu_a >> alu_b[4:0]; vf = 1'b0; cf = 1'b0; end
        OP_SRA: begin alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]); vf = 1'b0; cf = 1'b0; end
        default: ;  // JMPL, SAVE, RESTORE and unlisted codes: address add
      endcase
    end
  end

  // Flags load only for the cc bank (alu_op[5:4] == 01).
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) {n, z, v, c} <= '0;
    else if (alue && !alu_op[5] && alu_op[CC_BIT])
      {n, z, v, c} <= {alu_out[31], alu_out == 32'd0, vf, cf};
  end

  // ---- trap-base adder (wraps modulo 2^32) ----
  assign tb_out = tb_add ? tbr_in + 32'(TB_STEP) : tbr_in;

endmodule

// File: tb/tb_sparc_exec_unit.sv
// tb_sparc_exec_unit: directed steps followed by randomized traffic, checked
// against a behavioural model (flat physical register array indexed by the
// window formula, integer-arithmetic ALU, flag register).
module tb_sparc_exec_unit;

  logic        Clk = 1'b0, Clr = 1'b1;
  logic [1:0]  cwp = '0;
  logic [4:0]  ra = '0, rb = '0, rc = '0;
  logic [31:0] rin = '0, alu_a = '0, alu_b = '0, tbr_in = '0;
  logic        rfe = 1'b1, carry_in = 1'b0, alue = 1'b0, tb_add = 1'b0;
  logic [5:0]  alu_op = '0;
  logic [31:0] a_out, b_out, alu_out, tb_out;
  logic        n, z, v, c;

  int checks = 0, failures = 0;

  logic [31:0] mrf [72];
  logic [3:0]  mflags;

  sparc_exec_unit dut (
    .Clk(Clk), .Clr(Clr), .cwp(cwp), .ra(ra), .rb(rb), .rc(rc), .rin(rin),
    .rfe(rfe), .a_out(a_out), .b_out(b_out), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .carry_in(carry_in), .alue(alue), .alu_out(alu_out),
    .n(n), .z(z), .v(v), .c(c), .tbr_in(tbr_in), .tb_add(tb_add), .tb_out(tb_out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int phys(input int w, input int r);
    if (r < 8) return r;
    return 8 + ((w * 16 + (r - 8)) % 64);
  endfunction

  function automatic logic [31:0] mread(input int w, input int r);
    if (r == 0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (!rfe && rc != 0 && phys(w, r) == phys(w, int'(rc))) return rin;
`endif
    return mrf[phys(w, r)];
  endfunction

  // Reference ALU: arithmetic done in 64-bit integers, overflow by range check.
  function automatic void model_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, output logic [31:0] r, output logic [3:0] f);
    int          kind;  // 0 add, 1 sub, 2 logic/shift
    logic        cu;
    logic [63:0] ua, ub, us;
    longint      sa, sb, ss;
    logic        cf, vf;
    ua = {32'd0, a}; ub = {32'd0, b};
    sa = longint'($signed(a)); sb = longint'($signed(b));
    kind = 0; cu = 1'b0; r = '0; cf = 1'b0; vf = 1'b0;
    if (op[5] == 1'b0) begin
      case (op[3:0])
        4'd1:  begin r = a & b;    kind = 2; end
        4'd2:  begin r = a | b;    kind = 2; end
        4'd3:  begin r = a ^ b;    kind = 2; end
        4'd4:  kind = 1;
        4'd5:  begin r = a & ~b;   kind = 2; end
        4'd6:  begin r = a | ~b;   kind = 2; end
        4'd7:  begin r = ~(a ^ b); kind = 2; end
        4'd8:  cu = ci;
        4'd12: begin kind = 1; cu = ci; end
        default: ;
      endcase
    end else if (op == 6'b100101) begin r = a << b[4:0]; kind = 2; end
    else if (op == 6'b100110) begin r = a >> b[4:0]; kind = 2; end
    else if (op == 6'b100111) begin
      r = (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
      kind = 2;
    end
    if (kind == 0) begin
      us = ua + ub + 64'(cu); r = us[31:0]; cf = (us >= 64'h1_0000_0000);
      ss = sa + sb + longint'(cu);
      vf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end else if (kind == 1) begin
      r = a - b - 32'(cu); cf = (ua < ub + 64'(cu));
      ss = sa - sb - longint'(cu);
      vf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
    f = {r[31], r == 32'd0, vf, cf};
  endfunction

  // One clock edge, with the model taking the same edge's effects.
  task automatic tick();
    logic [31:0] r;
    logic [3:0]  f;
    logic        do_w, do_f;
    int          wi;
    model_alu(alu_op, alu_a, alu_b, carry_in, r, f);
    do_w = !rfe && rc != 0;
    wi   = phys(int'(cwp), int'(rc));
    do_f = alue && alu_op[5:4] == 2'b01;
    @(posedge Clk); #1;
    if (do_w) mrf[wi] = rin;
    if (do_f) mflags = f;
  endtask

  task automatic set_rf(input logic [1:0] w, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] wc, input logic [31:0] d, input logic en_n);
    cwp = w; ra = a; rb = b; rc = wc; rin = d; rfe = en_n;
  endtask

  task automatic set_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic fe);
    alu_op = op; alu_a = a; alu_b = b; carry_in = ci; alue = fe;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] r;
    logic [3:0]  f;
    model_alu(alu_op, alu_a, alu_b, carry_in, r, f);
    chk({tag, "_a"},   a_out,   mread(int'(cwp), int'(ra)));
    chk({tag, "_b"},   b_out,   mread(int'(cwp), int'(rb)));
    chk({tag, "_alu"}, alu_out, r);
    chk({tag, "_tb"},  tb_out,  tbr_in + (tb_add ? 32'd4 : 32'd0));
    chk({tag, "_flg"}, {28'd0, n, z, v, c}, {28'd0, mflags});
  endtask

  initial begin
    foreach (mrf[i]) mrf[i] = '0;
    mflags = '0;

    // Write and flag update attempted while reset is held: reset must win.
    set_rf(2'd0, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, 1'b0);
    set_alu(6'b010000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    set_rf(2'd0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b1);
    #2;
    chk("rst_hold_r5", a_out, 32'h0);
    chk("rst_hold_flags", {28'd0, n, z, v, c}, 32'h0);
    Clr = 1'b0;

    // Reset state with zero inputs.
    set_rf(2'd0, 5'd0, 5'd5, 5'd0, 32'h0, 1'b1);
    set_alu(6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_r0", a_out, 32'h0);
    chk("rst_r5", b_out, 32'h0);
    chk("rst_alu", alu_out, 32'h0);
    chk("rst_tb", tb_out, 32'h0);
    tick();

    // r0 write is discarded.
    set_rf(2'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0); tick();
    set_rf(2'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1); #2;
    chk("r0_write", a_out, 32'h0);

    // Window overlap: outs of w1 == ins of w0; wrap from w3 to w0.
    set_rf(2'd1, 5'd0, 5'd0, 5'd8, 32'hA5A5_A5A5, 1'b0); tick();
    set_rf(2'd0, 5'd24, 5'd8, 5'd0, 32'h0, 1'b1); #2;
    chk("ovl_w0_r24", a_out, 32'hA5A5_A5A5);
    set_rf(2'd3, 5'd0, 5'd0, 5'd24, 32'h1234_5678, 1'b0); tick();
    set_rf(2'd0, 5'd8, 5'd24, 5'd0, 32'h0, 1'b1); #2;
    chk("wrap_w0_r8", a_out, 32'h1234_5678);
    chk("wrap_w0_r24", b_out, 32'hA5A5_A5A5);

    // Globals are shared by all windows.
    set_rf(2'd2, 5'd0, 5'd0, 5'd3, 32'hCAFE_0003, 1'b0); tick();
    set_rf(2'd0, 5'd3, 5'd0, 5'd0, 32'h0, 1'b1); #2;
    chk("global_r3", a_out, 32'hCAFE_0003);

    // Same-cycle read of the register being written.
    set_rf(2'd0, 5'd3, 5'd0, 5'd3, 32'h0BAD_F00D, 1'b0); #2;
`ifdef RF_BYPASS_EN
    chk("raw_same_cycle", a_out, 32'h0BAD_F00D);
`else
    chk("raw_same_cycle", a_out, 32'hCAFE_0003);
`endif
    tick();
    set_rf(2'd0, 5'd3, 5'd0, 5'd0, 32'h0, 1'b1); #2;
    chk("raw_after", a_out, 32'h0BAD_F00D);

    // ADDcc overflow.
    set_alu(6'b010000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1); #2;
    chk("addcc_res", alu_out, 32'h8000_0000);
    tick();
    chk("addcc_flags", {28'd0, n, z, v, c}, 32'b1010);
    // SUBcc equal, then a disabled SUBcc that would borrow.
    set_alu(6'b010100, 32'h5, 32'h5, 1'b0, 1'b1); tick();
    chk("subcc_flags", {28'd0, n, z, v, c}, 32'b0100);
    set_alu(6'b010100, 32'h0, 32'h1, 1'b0, 1'b0); tick();
    chk("subcc_hold", {28'd0, n, z, v, c}, 32'b0100);
    // Non-cc op with alue=1 must not touch flags.
    set_alu(6'b000100, 32'h0, 32'h1, 1'b0, 1'b1); tick();
    chk("sub_nocc_hold", {28'd0, n, z, v, c}, 32'b0100);

    set_alu(6'b100111, 32'h8000_0000, 32'h4, 1'b0, 1'b0); #2;
    chk("sra", alu_out, 32'hF800_0000);
    set_alu(6'b001000, 32'h1, 32'h1, 1'b1, 1'b0); #2;
    chk("addx", alu_out, 32'h3);
    set_alu(6'b001100, 32'h5, 32'h2, 1'b1, 1'b0); #2;
    chk("subx", alu_out, 32'h2);
    set_alu(6'b111100, 32'h100, 32'h20, 1'b1, 1'b0); #2;
    chk("save_addr", alu_out, 32'h120);

    tbr_in = 32'h0000_0810; tb_add = 1'b0; #1;
    chk("tb_pass", tb_out, 32'h0000_0810);
    tb_add = 1'b1; #1;
    chk("tb_step", tb_out, 32'h0000_0814);
    tbr_in = 32'hFFFF_FFFC; #1;
    chk("tb_wrap", tb_out, 32'h0000_0000);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      set_rf(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, ($urandom_range(0, 3) == 0));
      set_alu(6'($urandom), a, b, 1'($urandom), 1'($urandom));
      tbr_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      tb_add = 1'($urandom);
      #2;
      chk_model("rnd");
      tick();
    end
    set_rf(2'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
    #2;
    chk_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
